// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the instruction sequencer.
//   - state_t   : sequencer FSM states
//   - OPC_*     : 3-bit major opcodes (ir[15:13])
//   - OP_*      : 2-bit sub-operations (ir[12:11])
//   - WB_*      : register-file write-back source select encodings
package cpu_pkg;

  typedef enum logic [3:0] {
    S_RST,
    S_IF1,
    S_IF2,
    S_UPC,
    S_DEC,
    S_GETA,
    S_GETB,
    S_EXEC,
    S_WB,
    S_MADDR,
    S_MRD,
    S_MWB,
    S_MWR,
    S_HALT
  } state_t;

  localparam logic [2:0] OPC_LDR  = 3'b011;
  localparam logic [2:0] OPC_STR  = 3'b100;
  localparam logic [2:0] OPC_ALU  = 3'b101;
  localparam logic [2:0] OPC_MOV  = 3'b110;
  localparam logic [2:0] OPC_HALT = 3'b111;

  localparam logic [1:0] OP_MOV_REG = 2'b00;
  localparam logic [1:0] OP_CMP     = 2'b01;
  localparam logic [1:0] OP_MOV_IMM = 2'b10;

  localparam logic [1:0] WB_C   = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;
  localparam logic [1:0] WB_PC  = 2'b11;

endpackage

// File: rtl/instr_dec.sv
// instr_dec: pure combinational split of the instruction register into fields.
// Ports:
//   ir     in  16  instruction register
//   opcode out 3   ir[15:13]
//   op     out 2   ir[12:11]
//   rn     out 3   ir[10:8]
//   rd     out 3   ir[7:5]
//   rm     out 3   ir[2:0]
//   imm8   out 8   ir[7:0]
//   imm5   out 5   ir[4:0]
module instr_dec (
  input  logic [15:0] ir,
  output logic [2:0]  opcode,
  output logic [1:0]  op,
  output logic [2:0]  rn,
  output logic [2:0]  rd,
  output logic [2:0]  rm,
  output logic [7:0]  imm8,
  output logic [4:0]  imm5
);

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign rm     = ir[2:0];
  assign imm8   = ir[7:0];
  assign imm5   = ir[4:0];

endmodule

// File: rtl/instr_seq_ctrl.sv
// instr_seq_ctrl: Moore-style instruction sequencer for a small 16-bit CPU.
// Fetches from a synchronous RAM, decodes, and steps the datapath through
// register reads, execute, write-back and load/store memory phases.
// Ports:
//   clk, rst (async, active-high)
//   start_pc   in  8   PC loaded when the RST state is left
//   mem_rdata  in  16  RAM read data, valid the cycle after mem_rd
//   dp_c       in  16  datapath C result (address / store data)
//   mem_addr, mem_rd, mem_wr, mem_wdata   RAM interface
//   ir, pc                                architectural registers
//   rf_rd_num, rf_wr_num, rf_wr_en, wb_sel register-file control
//   load_a, load_b, load_c, load_s, asel, bsel  datapath strobes
//   halted                                HALT reached
module instr_seq_ctrl
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  start_pc,
  input  logic [15:0] mem_rdata,
  input  logic [15:0] dp_c,
  output logic [7:0]  mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [15:0] mem_wdata,
  output logic [15:0] ir,
  output logic [7:0]  pc,
  output logic [2:0]  rf_rd_num,
  output logic [2:0]  rf_wr_num,
  output logic        rf_wr_en,
  output logic [1:0]  wb_sel,
  output logic        load_a,
  output logic        load_b,
  output logic        load_c,
  output logic        load_s,
  output logic        asel,
  output logic        bsel,
  output logic        halted
);

  state_t     state;
  logic [7:0] addr_q;     // data address captured in MADDR
  logic       addr_done;  // STR: address phase finished, now on data phase

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op;
  logic [7:0] imm8;
  logic [4:0] imm5;

  instr_dec u_dec (
    .ir     (ir),
    .opcode (opcode),
    .op     (op),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .imm8   (imm8),
    .imm5   (imm5)
  );

  // Immediates are routed to the datapath straight from ir; the sequencer
  // itself never looks at them.
  logic unused_imm;
  assign unused_imm = ^{imm8, imm5};

  logic is_ldr, is_str, is_alu, is_cmp, is_mov_reg, is_mov_imm, is_halt;
  assign is_ldr     = (opcode == OPC_LDR);
  assign is_str     = (opcode == OPC_STR);
  assign is_alu     = (opcode == OPC_ALU);
  assign is_cmp     = is_alu && (op == OP_CMP);
  assign is_mov_reg = (opcode == OPC_MOV) && (op == OP_MOV_REG);
  assign is_mov_imm = (opcode == OPC_MOV) && (op == OP_MOV_IMM);
  assign is_halt    = (opcode == OPC_HALT);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the async reset never touches start_pc, which is only
  // sampled on the clocked RST -> IF1 transition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_RST;
      pc        <= 8'h00;
      ir        <= 16'h0000;
      addr_q    <= 8'h00;
      addr_done <= 1'b0;
    end else begin
      case (state)
        S_RST: begin
          pc    <= start_pc;
          state <= S_IF1;
        end
        S_IF1: begin
          addr_done <= 1'b0;
          state     <= S_IF2;
        end
        S_IF2: begin
          ir    <= mem_rdata;
          state <= S_UPC;
        end
        S_UPC: begin
          pc    <= pc + 8'd1;  // wraps 0xFF -> 0x00
          state <= S_DEC;
        end
        S_DEC: begin
          if (is_mov_imm)                    state <= S_WB;
          else if (is_halt)                  state <= S_HALT;
          else if (is_mov_reg)               state <= S_GETB;
          else if (is_alu || is_ldr || is_str) state <= S_GETA;
          else                               state <= S_IF1;
        end
        // Load/store compute the address (Rn + imm5) before reading Rm/Rd.
        S_GETA:  state <= (is_ldr || is_str) ? S_EXEC : S_GETB;
        S_GETB:  state <= S_EXEC;
        S_EXEC: begin
          if (is_cmp)      state <= S_IF1;
          else if (is_ldr) state <= S_MADDR;
          else if (is_str) state <= addr_done ? S_MWR : S_MADDR;
          else             state <= S_WB;
        end
        S_MADDR: begin
          addr_q    <= dp_c[7:0];
          addr_done <= 1'b1;
          state     <= is_str ? S_GETB : S_MRD;
        end
        S_MRD:   state <= S_MWB;
        S_MWB:   state <= S_IF1;
        S_MWR:   state <= S_IF1;
        S_WB:    state <= S_IF1;
        S_HALT:  state <= S_HALT;
        default: state <= S_RST;
      endcase
    end
  end

  // Outputs decode from registered state so an async reset removes every
  // strobe immediately, including a write already on the bus.
  // NOTE: every output gets a default before the case so no latch is inferred.
  always_comb begin
    mem_addr  = pc;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 16'h0000;
    rf_rd_num = rn;
    rf_wr_num = rd;
    rf_wr_en  = 1'b0;
    wb_sel    = WB_C;
    load_a    = 1'b0;
    load_b    = 1'b0;
    load_c    = 1'b0;
    load_s    = 1'b0;
    asel      = 1'b0;
    bsel      = 1'b0;
    halted    = 1'b0;
    case (state)
      S_IF1:  mem_rd = 1'b1;
      S_GETA: load_a = 1'b1;
      S_GETB: begin
        rf_rd_num = is_str ? rd : rm;
        load_b    = 1'b1;
      end
      S_EXEC: begin
        load_c = 1'b1;
        load_s = is_cmp;
        asel   = is_mov_reg || (is_str && addr_done);
        bsel   = is_ldr || (is_str && !addr_done);
      end
      S_WB: begin
        rf_wr_en = 1'b1;
        if (is_mov_imm) begin
          rf_wr_num = rn;
          wb_sel    = WB_IMM;
        end
      end
      S_MRD: begin
        mem_addr = addr_q;
        mem_rd   = 1'b1;
      end
      S_MWB: begin
        rf_wr_en = 1'b1;
        wb_sel   = WB_MEM;
      end
      S_MWR: begin
        mem_addr  = addr_q;
        mem_wr    = 1'b1;
        mem_wdata = dp_c;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule
